// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding register, so a new word
// can be taken while the current one shifts and the output bit stream stays gapless.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic [CW-1:0]    r_cnt;
    logic             r_hold_full;

    logic             w_accept;
    logic             w_last;
    logic             w_head;
    logic [WIDTH-1:0] w_shifted;

    // Ready comes only from the hold flag, so there is no path from din_valid to din_ready.
    assign din_ready = ~r_hold_full;
    assign w_accept  = din_valid & ~r_hold_full;
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_head    = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[WIDTH-1:1]};

    assign out_valid = (r_state == ST_SHIFT);
    assign out       = (r_state == ST_SHIFT) & w_head;
    assign busy      = (r_state == ST_SHIFT) | r_hold_full;

    // Serializer state machine: load, shift, hand over from hold or bypass on the last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift <= din;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_shift <= w_shifted;
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_accept) begin
                            r_hold      <= din;
                            r_hold_full <= 1'b1;
                        end else begin
                            r_hold_full <= r_hold_full;
                        end
                    end else if (r_hold_full) begin
                        r_shift <= r_hold;
                        r_cnt   <= '0;
                        if (w_accept) begin
                            r_hold <= din;
                        end else begin
                            r_hold_full <= 1'b0;
                        end
                    end else if (w_accept) begin
                        // Word arriving on the last-bit edge skips the holding register.
                        r_shift <= din;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Purpose: parallel-in/serial-out stage that feeds the serial bit input of the 110011 sequence detector. It accepts words over a valid/ready handshake and emits a gapless bit stream.

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 shifts the MSB out first, 0 shifts the LSB out first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port din_valid, input, 1 bit: din holds a word.
REQ-007 SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port out, output, 1 bit: serial data bit, wired to the detector's serial input.
REQ-009 SHALL have port out_valid, output, 1 bit: out carries a real data bit this cycle.
REQ-010 SHALL have port busy, output, 1 bit: a word is shifting or held.

Function
REQ-011 SHALL hold a shift register (WIDTH), a bit counter (ceil(log2 WIDTH)), a holding register (WIDTH) and a hold_full flag.
REQ-012 SHALL implement two states: IDLE and SHIFT.
REQ-013 SHALL accept a word only on a clock edge where din_valid=1 and din_ready=1; without that, din is ignored.
REQ-014 SHALL drive din_ready = !hold_full, decoded from registers only, with no combinational path from din_valid.
REQ-015 On an accept in IDLE: SHALL load din into the shift register, clear the counter to 0 and go to SHIFT; hold_full SHALL stay 0.
REQ-016 In SHIFT: SHALL drive out_valid=1 and out = the current head bit (MSB if MSB_FIRST=1, else LSB).
REQ-017 Each SHIFT edge with counter < WIDTH-1: SHALL shift by one and increment the counter.
REQ-018 In SHIFT, when an accept occurs and this is not the last-bit edge: SHALL write din into the holding register and set hold_full.
REQ-019 On the last-bit edge (counter = WIDTH-1) with hold_full=1: SHALL transfer hold into the shift register and clear the counter, staying in SHIFT. hold_full clears unless a word is accepted on the same edge; that word SHALL then go into hold and hold_full stays 1.
REQ-020 On the last-bit edge with hold_full=0 and an accept: SHALL load din straight into the shift register, bypassing hold, and stay in SHIFT.
REQ-021 On the last-bit edge with hold_full=0 and no accept: SHALL go to IDLE.
REQ-022 Latency: a word accepted at edge N SHALL put bit 0 on out in the cycle after edge N; bit k SHALL appear in the cycle after edge N+k.
REQ-023 Consecutive words SHALL be emitted with zero idle cycles between their bits whenever the next word is accepted no later than the last-bit edge of the current word.
REQ-024 In IDLE: out_valid=0 and out=0. The detector sees these as 0 bits, so stream gaps break pattern continuity, by design.
REQ-025 SHALL drive busy = (state==SHIFT) | hold_full.
REQ-026 SHALL never drop, duplicate or reorder an accepted word.

Reset
REQ-027 reset=0 SHALL immediately clear all of the following regardless of clk: state to IDLE, counter to 0, shift register to 0, hold register to 0 and hold_full to 0.
REQ-028 During reset: out=0, out_valid=0, busy=0, din_ready=1.
REQ-029 A word in flight or held when reset asserts SHALL be discarded.
REQ-030 The first accept SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-031 Reset mid-word: load 8'hCC, assert reset after 3 bits -> out, out_valid and busy go to 0 asynchronously, din_ready=1, and no further bits are emitted.
REQ-032 Single word 8'hCC, MSB_FIRST=1 -> out = 1,1,0,0,1,1,0,0 over 8 consecutive cycles with out_valid high exactly 8 cycles, then IDLE; a downstream 110011 detector fires once.
REQ-033 Back-to-back: din_valid held with 8'h33 then 8'hF0 -> 16 gapless bits 0011001111110000; din_ready=0 while hold_full.
REQ-034 Bypass: a second word presented only on the last-bit edge with hold empty -> no idle cycle between words; hold_full stays 0.
REQ-035 Backpressure: din_valid held through din_ready=0 with three words queued -> each word accepted exactly once and emitted in order.
REQ-036 MSB_FIRST=0 with 8'h0B -> out = 1,1,0,1,0,0,0,0.
